// File: rtl/io_pkg.sv
// Shared constants and UART state encoding for the IO page responder.
// IO_UART_TX_PARITY_EN (optional) enables the even-parity bit in the UART frame.
package io_pkg;

    localparam int IO_PAGE_BIT = 22;

    localparam logic [1:0] IO_LEDS        = 2'd0;
    localparam logic [1:0] IO_UART_DATA   = 2'd1;
    localparam logic [1:0] IO_UART_STATUS = 2'd2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_OVERRUN = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Integer-truncated bit period in clock cycles.
    function automatic int uart_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// UART transmitter core: FSM, baud counter and shift register, LSB-first.
// IO_UART_TX_PARITY_EN inserts an even-parity bit between DATA and STOP.
module uart_tx_core
    import io_pkg::*;
#(
    parameter int DIV = 217
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       txd
);

    localparam int             CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(DIV - 1);

    uart_state_e   state_q, state_d;
    logic [CW-1:0] baud_q,  baud_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q,   txd_d;
    logic          tick;
`ifdef IO_UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign tick = (baud_q == BAUD_LAST);
    assign busy = (state_q != IDLE);
    assign txd  = txd_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef IO_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != IDLE) begin
            baud_d = tick ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = START;
                    shift_d = data;
                    baud_d  = '0;
                    bit_d   = '0;
`ifdef IO_UART_TX_PARITY_EN
                    parity_d = ^data;
`endif
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef IO_UART_TX_PARITY_EN
            PARITY: begin
                if (tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (tick) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level is registered from the current state, so it trails the FSM by one cycle.
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
`ifdef IO_UART_TX_PARITY_EN
            PARITY:  txd_d = parity_q;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
`ifdef IO_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
`ifdef IO_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// IO page responder: LED register, UART TX data/status registers and read mux.
// IO_UART_TX_PARITY_EN (optional) adds an even-parity bit to each UART frame.
module io_uart_tx
    import io_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int BAUD        = 115200
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] io_rdata,
    output logic [7:0]  leds,
    output logic        uart_txd
);

    localparam int DIV = uart_div(CLK_FREQ_HZ, BAUD);

    logic        io_sel;
    logic [1:0]  reg_idx;
    logic        wr_en;
    logic        rd_en;
    logic        tx_busy;
    logic        tx_start;
    logic [31:0] status;

    logic [31:0] rdata_q,   rdata_d;
    logic [7:0]  leds_q,    leds_d;
    logic        overrun_q, overrun_d;

    logic        unused_bits;

    assign io_sel   = mem_addr[IO_PAGE_BIT];
    assign reg_idx  = mem_addr[3:2];
    assign wr_en    = io_sel && (mem_wmask != 4'b0000);
    assign rd_en    = io_sel && mem_rstrb;
    assign tx_start = wr_en && (reg_idx == IO_UART_DATA) && !tx_busy;

    assign unused_bits = ^{mem_addr[31:23], mem_addr[21:4], mem_addr[1:0], mem_wdata[31:8]};

    always_comb begin
        status               = '0;
        status[STAT_BUSY]    = tx_busy;
        status[STAT_OVERRUN] = overrun_q;
    end

    always_comb begin
        leds_d    = leds_q;
        overrun_d = overrun_q;
        if (wr_en) begin
            case (reg_idx)
                IO_LEDS:        leds_d = mem_wdata[7:0];
                IO_UART_DATA:   if (tx_busy) overrun_d = 1'b1;
                IO_UART_STATUS: if (mem_wdata[STAT_OVERRUN]) overrun_d = 1'b0;
                default:        ;
            endcase
        end
    end

    // Reads see the registers as they were before any same-cycle write.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (reg_idx)
                IO_LEDS:        rdata_d = {24'h0, leds_q};
                IO_UART_STATUS: rdata_d = status;
                default:        rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q   <= '0;
            leds_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            rdata_q   <= rdata_d;
            leds_q    <= leds_d;
            overrun_q <= overrun_d;
        end
    end

    uart_tx_core #(
        .DIV (DIV)
    ) u_core (
        .clk    (clk),
        .resetn (resetn),
        .start  (tx_start),
        .data   (mem_wdata[7:0]),
        .busy   (tx_busy),
        .txd    (uart_txd)
    );

    assign io_rdata = rdata_q;
    assign leds     = leds_q;

endmodule
